// File: rtl/vco_adc_pkg.sv
// vco_adc_pkg: shared types, defaults and helpers for the VCO-ADC capture path.
package vco_adc_pkg;

    localparam int NCH_DEF = 3;
    localparam int AW_DEF  = 9;
    localparam int DW_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } cap_state_e;

    // A programmed depth of zero selects the full bank (2^aw words).
    function automatic int eff_depth(input int aw, input int depth);
        return (depth == 0) ? (1 << aw) : depth;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; priority starts just after the last
// granted requester and returns to requester 0 on reset or clr.
module rr_arbiter #(
    parameter int NCH = 3,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  gnt_idx,
    output logic           gnt_any
);

    logic [IW-1:0] ptr_q;

    // Scan requesters starting at the priority pointer, take the first one.
    always_comb begin
        int c;
        c       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            c = int'(ptr_q) + i;
            if (c >= NCH) c = c - NCH;
            if (en && !gnt_any && req[c]) begin
                gnt[c]  = 1'b1;
                gnt_idx = IW'(c);
                gnt_any = 1'b1;
            end
        end
    end

    // Priority pointer moves to the requester after the one just granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (clr) begin
            ptr_q <= '0;
        end else if (gnt_any) begin
            ptr_q <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/adc_capture_scheduler.sv
// adc_capture_scheduler: collects per-channel decimator samples into one-entry
// holding registers and writes them round-robin into a ping-pong pair of SRAM
// banks, handing each finished bank to software with an interrupt.
module adc_capture_scheduler
    import vco_adc_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [NCH-1:0]    ch_en_i,
    input  logic [AW-1:0]     depth_i,
    input  logic [NCH-1:0]    adc_dvalid_i,
    input  logic [NCH*DW-1:0] adc_dat_i,
    input  logic [1:0]        bank_ack_i,
    output logic [1:0]        mem_wenb_o,
    output logic [AW-1:0]     mem_waddr_o,
    output logic [DW-1:0]     mem_data_o,
    output logic [3:0]        wmask_o,
    output logic [1:0]        bank_full_o,
    output logic [AW:0]       fill_cnt_o,
    output logic [NCH-1:0]    overflow_o,
    output logic              irq_o,
    output logic              busy_o
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    cap_state_e     state_q, state_d;
    logic           bank_q;
    logic [AW-1:0]  wptr_q;
    logic [AW:0]    fill_q;
    logic [AW:0]    depth_eff;
    logic [1:0]     full_q, full_d;
    logic [NCH-1:0] ovf_q;
    logic           irq_q;
    logic [NCH-1:0] vld_p0, vld_d, load, ovf_set;
    logic [DW-1:0]  hold_p0 [NCH];
    logic           active, accept, grant_en, last_wr;
    logic [NCH-1:0] gnt;
    logic [IW-1:0]  gnt_idx;
    logic           gnt_any;

    assign depth_eff   = (AW+1)'(eff_depth(AW, int'(depth_i)));
    assign active      = (state_q != ST_IDLE);
    assign accept      = active && !stop_i && !start_i;
    assign grant_en    = (state_q == ST_RUN) && !full_q[bank_q] && !stop_i && !start_i;
    assign last_wr     = gnt_any && ((fill_q + 1'b1) >= depth_eff);

    assign bank_full_o = full_q;
    assign fill_cnt_o  = fill_q;
    assign overflow_o  = ovf_q;
    assign irq_o       = irq_q;
    assign busy_o      = active;

    rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (start_i),
        .en      (grant_en),
        .req     (vld_p0),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Next state: stop beats start; stall while the active bank is still full.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i && !stop_i) state_d = ST_RUN;
            ST_RUN: begin
                if (stop_i)       state_d = ST_IDLE;
                else if (start_i) state_d = ST_RUN;
                else if (full_q[bank_q] && !bank_ack_i[bank_q]) state_d = ST_STALL;
            end
            ST_STALL: begin
                if (stop_i)       state_d = ST_IDLE;
                else if (start_i) state_d = ST_RUN;
                else if (bank_ack_i[bank_q] || !full_q[bank_q]) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Per-channel capture: load when empty or being drained, else flag overflow.
    always_comb begin
        vld_d   = vld_p0 & ~gnt;
        load    = '0;
        ovf_set = '0;
        for (int k = 0; k < NCH; k++) begin
            if (accept && adc_dvalid_i[k] && ch_en_i[k]) begin
                if (!vld_p0[k] || gnt[k]) begin
                    load[k]  = 1'b1;
                    vld_d[k] = 1'b1;
                end else begin
                    ovf_set[k] = 1'b1;
                end
            end
        end
    end

    // Bank-full flags: software ack clears, a completed or stopped block sets (set wins).
    always_comb begin
        full_d = full_q & ~bank_ack_i;
        if (stop_i) begin
            if (active && (fill_q != '0)) full_d[bank_q] = 1'b1;
        end else if (start_i) begin
            full_d = '0;
        end else if (last_wr) begin
            full_d[bank_q] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // p0: holding registers carry no reset; vld_p0 qualifies them.
    always_ff @(posedge wb_clk_i) begin
        for (int k = 0; k < NCH; k++) begin
            if (load[k]) hold_p0[k] <= adc_dat_i[k*DW +: DW];
        end
    end

    // p1: registered SRAM write port, bank pointers and status flags.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            vld_p0      <= '0;
            ovf_q       <= '0;
            full_q      <= '0;
            irq_q       <= 1'b0;
            bank_q      <= 1'b0;
            wptr_q      <= '0;
            fill_q      <= '0;
            mem_wenb_o  <= 2'b11;
            mem_waddr_o <= '0;
            mem_data_o  <= '0;
            wmask_o     <= '0;
        end else begin
            full_q     <= full_d;
            irq_q      <= 1'b0;
            mem_wenb_o <= 2'b11;
            wmask_o    <= '0;
            if (stop_i) begin
                vld_p0 <= '0;
                if (active && (fill_q != '0)) irq_q <= 1'b1;
            end else if (start_i) begin
                vld_p0 <= '0;
                ovf_q  <= '0;
                bank_q <= 1'b0;
                wptr_q <= '0;
                fill_q <= '0;
            end else if (active) begin
                vld_p0 <= vld_d;
                ovf_q  <= ovf_q | ovf_set;
                if (gnt_any) begin
                    mem_wenb_o  <= bank_q ? 2'b01 : 2'b10;
                    mem_waddr_o <= wptr_q;
                    mem_data_o  <= hold_p0[gnt_idx];
                    wmask_o     <= 4'hF;
                    if (last_wr) begin
                        wptr_q <= '0;
                        fill_q <= '0;
                        bank_q <= ~bank_q;
                        irq_q  <= 1'b1;
                    end else begin
                        wptr_q <= wptr_q + 1'b1;
                        fill_q <= fill_q + 1'b1;
                    end
                end
            end
        end
    end

endmodule
